// File: rtl/bus_transfer_sched.sv
// Round-robin scheduler for register-to-register moves on the shared CPU data bus.
// Drives the active-low assert/load strobes of the bus registers; all outputs registered.
module bus_transfer_sched #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_REG       = 8,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] req_src,
  input  logic [NUM_REQ*SEL_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic [NUM_REG-1:0]       assert_n,
  output logic [NUM_REG-1:0]       load_n
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PTR_W-1:0] rr_ptr, ptr_nx;
  logic [PTR_W-1:0] gnt, gnt_nx;
  logic [SEL_W-1:0] src, src_nx;
  logic [SEL_W-1:0] dst, dst_nx;
  logic             bad, bad_nx;
  logic             found;
  logic [PTR_W-1:0] sel;
  int unsigned      idx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = rr_ptr;
    gnt_nx   = gnt;
    src_nx   = src;
    dst_nx   = dst;
    bad_nx   = bad;
    found    = 1'b0;
    sel      = '0;
    idx      = 0;
    case (state)
      IDLE: begin
        if (|req) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[PTR_W'(idx)]) begin
              found = 1'b1;
              sel   = PTR_W'(idx);
            end
          end
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == PTR_W'(i)) begin
              src_nx = req_src[i*SEL_W +: SEL_W];
              dst_nx = req_dst[i*SEL_W +: SEL_W];
            end
          end
          gnt_nx   = sel;
          ptr_nx   = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          // Extra MSB keeps the range check correct when NUM_REG == 2**SEL_W.
          bad_nx   = ({1'b0, src_nx} >= (SEL_W+1)'(NUM_REG)) ||
                     ({1'b0, dst_nx} >= (SEL_W+1)'(NUM_REG)) ||
                     (src_nx == dst_nx);
          cnt_nx   = CNT_W'(SETTLE_CYCLES - 1);
          state_nx = bad_nx ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) state_nx = LOAD;
        else           cnt_nx   = cnt - 1'b1;
      end
      LOAD:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so strobes line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      gnt      <= '0;
      src      <= '0;
      dst      <= '0;
      bad      <= 1'b0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      assert_n <= '1;
      load_n   <= '1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rr_ptr   <= ptr_nx;
      gnt      <= gnt_nx;
      src      <= src_nx;
      dst      <= dst_nx;
      bad      <= bad_nx;
      busy     <= (state_nx != IDLE);
      err      <= (state_nx == DONE) && bad_nx;
      for (int unsigned k = 0; k < NUM_REG; k++) begin
        assert_n[k] <= !(((state_nx == DRIVE) || (state_nx == LOAD)) && (src_nx == SEL_W'(k)));
        load_n[k]   <= !((state_nx == LOAD) && (dst_nx == SEL_W'(k)));
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        done[k] <= (state_nx == DONE) && (gnt_nx == PTR_W'(k));
      end
    end
  end

endmodule
